// File: rtl/servo_slew_ctrl.sv
// Hobby-servo PWM sequencer: maps an angle command to a pulse width and slews the live duty
// toward it by at most STEP per frame. Optional status LEDs under SERVO_STATUS_LED_EN.
module servo_slew_ctrl #(
  parameter int FRAME_CYCLES = 500_000,
  parameter int DUTY_MIN     = 25_000,
  parameter int DUTY_MAX     = 50_000,
  parameter int STEP         = 250,
  parameter int HOLD_FRAMES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_angle,
  output logic        servo_pin,
  output logic [18:0] duty,
  output logic        frame_tick,
  output logic        busy,
  output logic        done
`ifdef SERVO_STATUS_LED_EN
  ,
  output logic        led_verde,
  output logic        led_verm
`endif
);

  localparam int DW     = 19;
  localparam int PW     = 27;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [DW-1:0]     FC_LAST   = DW'(FRAME_CYCLES - 1);
  localparam logic [PW-1:0]     SPAN      = PW'(DUTY_MAX - DUTY_MIN);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Full-width product keeps every bit until after the >>8 scaling.
  function automatic logic [DW-1:0] map_angle(input logic [7:0] ang);
    return DW'(PW'(DUTY_MIN) + ((PW'(ang) * SPAN) >> 8));
  endfunction

  function automatic logic within_step(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic signed [DW:0] diff;
    logic signed [DW:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = (diff < 0) ? -diff : diff;
    return mag <= $signed((DW+1)'(STEP));
  endfunction

  function automatic logic [DW-1:0] sat_duty(input logic signed [DW+1:0] val);
    if (val < $signed((DW+2)'(DUTY_MIN))) return DW'(DUTY_MIN);
    if (val > $signed((DW+2)'(DUTY_MAX))) return DW'(DUTY_MAX);
    return DW'(val);
  endfunction

  function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic signed [DW+1:0] nxt;
    if (tgt > cur) nxt = $signed({2'b00, cur}) + $signed((DW+2)'(STEP));
    else           nxt = $signed({2'b00, cur}) - $signed((DW+2)'(STEP));
    return sat_duty(nxt);
  endfunction

  logic [1:0]        state_q,     state_d;
  logic [DW-1:0]     fc_q,        fc_d;
  logic [DW-1:0]     duty_q,      duty_d;
  logic [DW-1:0]     target_q,    target_d;
  logic [7:0]        angle_q,     angle_d;
  logic [HOLD_W-1:0] hold_q,      hold_d;
  logic [HOLD_W-1:0] hold_inc;
  logic              servo_pin_q, servo_pin_d;
  logic              done_q,      done_d;
  logic              tick;

  assign tick     = (fc_q == FC_LAST);
  assign hold_inc = hold_q + HOLD_W'(1);

  always_comb begin
    state_d     = state_q;
    angle_d     = angle_q;
    target_d    = target_q;
    duty_d      = duty_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    fc_d        = tick ? '0 : fc_q + DW'(1);
    servo_pin_d = (fc_q < duty_q);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          angle_d = cmd_angle;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        target_d = map_angle(angle_q);
        state_d  = S_MOVE;
      end
      S_MOVE: begin
        // Duty only moves on the frame-end edge so every pulse uses one width.
        if (tick) begin
          if (within_step(duty_q, target_q)) begin
            duty_d  = target_q;
            hold_d  = '0;
            state_d = S_HOLD;
          end else begin
            duty_d = step_toward(duty_q, target_q);
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    angle_q  <= angle_d;
    target_q <= target_d;
    hold_q   <= hold_d;
    if (rst) begin
      state_q     <= S_IDLE;
      fc_q        <= '0;
      duty_q      <= DW'(DUTY_MIN);
      servo_pin_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      duty_q      <= duty_d;
      servo_pin_q <= servo_pin_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign frame_tick = tick;
  assign duty       = duty_q;
  assign servo_pin  = servo_pin_q;
  assign done       = done_q;

`ifdef SERVO_STATUS_LED_EN
  logic led_verde_q, led_verde_d;
  logic led_verm_q,  led_verm_d;

  // Driven from the next state so the LEDs track busy with no extra lag.
  always_comb begin
    led_verde_d = (state_d == S_IDLE);
    led_verm_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_verde_q <= 1'b1;
      led_verm_q  <= 1'b0;
    end else begin
      led_verde_q <= led_verde_d;
      led_verm_q  <= led_verm_d;
    end
  end

  assign led_verde = led_verde_q;
  assign led_verm  = led_verm_q;
`endif

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Scoreboard bench for servo_slew_ctrl with shortened frames so full ramps fit in a short run.
module tb_servo_slew_ctrl;

  localparam int FC   = 120;
  localparam int DMIN = 40;
  localparam int DMAX = 100;
  localparam int STP  = 7;
  localparam int HOLD = 3;

  typedef struct {
    int duty;
    bit dn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_angle = 8'd0;
  logic        cmd_ready;
  logic        servo_pin;
  logic [18:0] duty;
  logic        frame_tick;
  logic        busy;
  logic        done;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   model_duty = DMIN;

  int   duty_exp = DMIN;
  bit   done_next = 1'b0;
  int   pwm_cnt = 0;
  bit   armed = 1'b0;
  exp_t mon_e;

  always #5 clk = ~clk;

  servo_slew_ctrl #(
    .FRAME_CYCLES(FC),
    .DUTY_MIN(DMIN),
    .DUTY_MAX(DMAX),
    .STEP(STP),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_angle(cmd_angle),
    .servo_pin(servo_pin),
    .duty(duty),
    .frame_tick(frame_tick),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected per-frame-end duty values for one command, ending with the done frame.
  task automatic push_ramp(input int tgt);
    int   d;
    exp_t e;
    d = model_duty;
    while (1) begin
      if ((tgt - d) <= STP && (d - tgt) <= STP) begin
        d = tgt;
        e.duty = d; e.dn = 1'b0;
        exp_q.push_back(e);
        break;
      end
      d = (tgt > d) ? d + STP : d - STP;
      e.duty = d; e.dn = 1'b0;
      exp_q.push_back(e);
    end
    for (int h = 1; h <= HOLD; h++) begin
      e.duty = d; e.dn = (h == HOLD);
      exp_q.push_back(e);
    end
    model_duty = d;
  endtask

  // Monitor: every cycle compares duty/done against the scoreboard state and
  // every frame compares the measured pulse width against the frame's duty.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("duty", int'(duty), duty_exp);
        chk("done", int'(done), int'(done_next));
      end
      done_next = 1'b0;
      if (rst) begin
        duty_exp = DMIN;
        pwm_cnt  = 0;
        armed    = 1'b1;
      end else begin
        if (servo_pin) pwm_cnt++;
        if (frame_tick) begin
          chk("pulse_width", pwm_cnt, duty_exp);
          pwm_cnt = 0;
          if (exp_q.size() > 0) begin
            mon_e     = exp_q.pop_front();
            duty_exp  = mon_e.duty;
            done_next = mon_e.dn;
          end
        end
      end
    end
  end

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_tick && n < 2 * FC) begin
      @(negedge clk);
      n++;
    end
    if (!frame_tick) chk("wait_tick_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready && exp_q.size() == 0) && n < 40 * FC) begin
      @(negedge clk);
      n++;
    end
    if (!(cmd_ready && exp_q.size() == 0)) chk("wait_idle_timeout", 0, 1);
  endtask

  // mode 0: present mid-frame; mode 1: present on a frame_tick cycle;
  // mode 2: present immediately while busy and expect it to be held off.
  task automatic issue(input logic [7:0] ang, input int tgt, input int mode);
    bit acc;
    bit done_here;
    int n;
    if (mode == 0) begin
      wait_tick();
      repeat (10) @(negedge clk);
    end else if (mode == 1) begin
      wait_tick();
    end else begin
      @(negedge clk);
    end
    cmd_angle = ang;
    cmd_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    done_here = 1'b0;
    while (n < 60 * FC) begin
      acc = cmd_ready;
      done_here = done;
      if (mode == 2 && n == 0) chk("ready_low_while_busy", int'(cmd_ready), 0);
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
      n++;
    end
    #1;
    cmd_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 0, 1);
    end else begin
      if (mode == 2) chk("held_accept_on_done", int'(done_here), 1);
      push_ramp(tgt);
      @(negedge clk);
      chk("busy_after_accept", int'(busy), 1);
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", int'(duty), DMIN);
    chk("rst_servo_pin", int'(servo_pin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_fc", int'(dut.fc_q), 0);

    // Two idle frames: pulse widths are checked by the monitor.
    repeat (2 * FC) @(negedge clk);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // 255 -> 40 + (255*60>>8) = 99
    issue(8'd255, 99, 0);
    wait_idle();
    chk("reach_255", int'(duty), 99);

    issue(8'd0, 40, 0);
    wait_idle();
    chk("reach_0", int'(duty), 40);

    // Same-as-current command, with a 128 command queued behind it.
    issue(8'd0, 40, 0);
    issue(8'd128, 70, 2);
    wait_idle();
    chk("reach_128", int'(duty), 70);

    // Reset partway through a ramp from 70 toward 99 (70 -> 77 -> 84).
    issue(8'd255, 99, 0);
    wait_tick();
    wait_tick();
    repeat (20) @(negedge clk);
    chk("pre_rst_duty", int'(duty), 84);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    model_duty = DMIN;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fc", int'(dut.fc_q), 0);
    chk("mid_rst_duty", int'(duty), DMIN);
    rst = 1'b0;
    repeat (2 * FC) @(negedge clk);
    chk("after_rst_ready", int'(cmd_ready), 1);

    // Command accepted on the frame_tick cycle: first step one frame later.
    issue(8'd128, 70, 1);
    wait_idle();
    chk("reach_128_tick", int'(duty), 70);

    repeat (FC) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
